// File: rtl/vga_box_renderer.sv
// rtl/vga_box_renderer.sv - bouncing-box pixel stage with one-pixel registered RGB and sync alignment
module vga_box_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2,
  parameter int X_START  = 0,
  parameter int Y_START  = 0
) (
  input  logic        clock50MHz,
  input  logic        inReset,
  input  logic        pixelEnable,
  input  logic        inHSync,
  input  logic        inVSync,
  input  logic        displayEnable,
  input  logic [9:0]  pixelX,
  input  logic [9:0]  pixelY,
  input  logic [11:0] boxColor,
  input  logic [11:0] bgColor,
  input  logic        pause,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  outRed,
  output logic [3:0]  outGreen,
  output logic [3:0]  outBlue,
  output logic [7:0]  frameCount
);

  typedef enum logic {RIGHT = 1'b0, LEFT = 1'b1} x_dir_t;
  typedef enum logic {DOWN = 1'b0, UP = 1'b1} y_dir_t;

  // 11-bit copies so position + size + step never wraps during comparisons
  localparam logic [10:0] H11    = 11'(H_ACTIVE);
  localparam logic [10:0] V11    = 11'(V_ACTIVE);
  localparam logic [10:0] BOX11  = 11'(BOX_SIZE);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [9:0]  STEP10 = 10'(STEP);
  localparam logic [9:0]  X_MAX  = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  X_INIT = 10'(X_START);
  localparam logic [9:0]  Y_INIT = 10'(Y_START);

  logic [9:0] box_x;
  logic [9:0] box_y;
  x_dir_t     dir_x;
  y_dir_t     dir_y;
  logic       vs_prev;

  logic       frame_tick;
  logic       in_box;
  logic [9:0] next_box_x;
  logic [9:0] next_box_y;
  x_dir_t     next_dir_x;
  y_dir_t     next_dir_y;

  assign frame_tick = vs_prev & ~inVSync;

  // Box hit test against the position held before any update on this pixel
  always_comb begin
    in_box = ({1'b0, pixelX} >= {1'b0, box_x}) &&
             ({1'b0, pixelX} <  ({1'b0, box_x} + BOX11)) &&
             ({1'b0, pixelY} >= {1'b0, box_y}) &&
             ({1'b0, pixelY} <  ({1'b0, box_y} + BOX11));
  end

  // Horizontal bounce: clamp to the edge and reverse when the next step would leave the area
  always_comb begin
    next_box_x = box_x;
    next_dir_x = dir_x;
    if (dir_x == RIGHT) begin
      if (({1'b0, box_x} + STEP11 + BOX11) > H11) begin
        next_box_x = X_MAX;
        next_dir_x = LEFT;
      end else begin
        next_box_x = box_x + STEP10;
      end
    end else begin
      if (box_x < STEP10) begin
        next_box_x = 10'd0;
        next_dir_x = RIGHT;
      end else begin
        next_box_x = box_x - STEP10;
      end
    end
  end

  // Vertical bounce: same rules as horizontal, bounded by the active line count
  always_comb begin
    next_box_y = box_y;
    next_dir_y = dir_y;
    if (dir_y == DOWN) begin
      if (({1'b0, box_y} + STEP11 + BOX11) > V11) begin
        next_box_y = Y_MAX;
        next_dir_y = UP;
      end else begin
        next_box_y = box_y + STEP10;
      end
    end else begin
      if (box_y < STEP10) begin
        next_box_y = 10'd0;
        next_dir_y = DOWN;
      end else begin
        next_box_y = box_y - STEP10;
      end
    end
  end

  // Render stage: syncs and colour registered together so they stay aligned at the pins
  always_ff @(posedge clock50MHz or negedge inReset) begin
    if (!inReset) begin
      hSync    <= 1'b1;
      vSync    <= 1'b1;
      outRed   <= 4'd0;
      outGreen <= 4'd0;
      outBlue  <= 4'd0;
    end else if (pixelEnable) begin
      hSync <= inHSync;
      vSync <= inVSync;
      if (!displayEnable) begin
        {outRed, outGreen, outBlue} <= 12'd0;
      end else if (in_box) begin
        {outRed, outGreen, outBlue} <= boxColor;
      end else begin
        {outRed, outGreen, outBlue} <= bgColor;
      end
    end
  end

  // Frame detection on the vSync falling edge; counting continues while paused
  always_ff @(posedge clock50MHz or negedge inReset) begin
    if (!inReset) begin
      vs_prev    <= 1'b1;
      frameCount <= 8'd0;
    end else if (pixelEnable) begin
      vs_prev <= inVSync;
      if (frame_tick) begin
        frameCount <= frameCount + 8'd1;
      end
    end
  end

  // Motion FSMs: position and direction advance once per frame unless paused
  always_ff @(posedge clock50MHz or negedge inReset) begin
    if (!inReset) begin
      box_x <= X_INIT;
      box_y <= Y_INIT;
      dir_x <= RIGHT;
      dir_y <= DOWN;
    end else if (pixelEnable && frame_tick && !pause) begin
      box_x <= next_box_x;
      box_y <= next_box_y;
      dir_x <= next_dir_x;
      dir_y <= next_dir_y;
    end
  end

endmodule

// File: tb/tb_vga_box_renderer.sv
// tb/tb_vga_box_renderer.sv - randomized scoreboard bench for vga_box_renderer
module tb_vga_box_renderer;

  localparam int H  = 640;
  localparam int V  = 35;
  localparam int B  = 32;
  localparam int S  = 2;
  localparam int XS = 606;
  localparam int YS = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pe = 1'b0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic        de = 1'b0;
  logic [9:0]  px = '0;
  logic [9:0]  py = '0;
  logic [11:0] box_c = '0;
  logic [11:0] bg_c = '0;
  logic        pause = 1'b0;
  logic        hs_out;
  logic        vs_out;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic [7:0]  frame_count;

  vga_box_renderer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .BOX_SIZE(B), .STEP(S), .X_START(XS), .Y_START(YS)
  ) dut (
    .clock50MHz(clk), .inReset(rst_n), .pixelEnable(pe), .inHSync(hs_in), .inVSync(vs_in),
    .displayEnable(de), .pixelX(px), .pixelY(py), .boxColor(box_c), .bgColor(bg_c),
    .pause(pause), .hSync(hs_out), .vSync(vs_out), .outRed(red), .outGreen(green),
    .outBlue(blue), .frameCount(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic [7:0]  fc;
  } exp_t;

  localparam exp_t RESET_EXP = '{hs: 1'b1, vs: 1'b1, rgb: 12'd0, fc: 8'd0};

  exp_t q[$];
  exp_t last = RESET_EXP;
  int   checks = 0;
  int   failures = 0;

  // reference model state (driver-owned)
  int   m_bx, m_by, m_dx, m_dy, m_fc;
  logic m_vsprev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bx = XS; m_by = YS; m_dx = 1; m_dy = 1; m_fc = 0; m_vsprev = 1'b1;
  endtask

  task automatic move(inout int pos, inout int dir, input int lim);
    int n;
    n = pos + dir * S;
    if (n + B > lim) begin
      pos = lim - B; dir = -1;
    end else if (n < 0) begin
      pos = 0; dir = 1;
    end else begin
      pos = n;
    end
  endtask

  function automatic exp_t current_out();
    return '{hs: hs_out, vs: vs_out, rgb: {red, green, blue}, fc: frame_count};
  endfunction

  // one enabled pixel followed by one disabled clock carrying garbage inputs
  task automatic drive_pixel(input logic h, input logic v, input logic d, input int x, input int y);
    exp_t e;
    logic [11:0] bc, gc;
    logic p;
    @(negedge clk);
    bc = 12'($urandom); gc = 12'($urandom); p = pause;
    hs_in = h; vs_in = v; de = d; px = 10'(x); py = 10'(y); box_c = bc; bg_c = gc; pe = 1'b1;
    e.hs = h; e.vs = v;
    if (!d) e.rgb = 12'd0;
    else if (x >= m_bx && x < m_bx + B && y >= m_by && y < m_by + B) e.rgb = bc;
    else e.rgb = gc;
    if (m_vsprev && !v) begin
      m_fc = (m_fc + 1) % 256;
      if (!p) begin
        move(m_bx, m_dx, H);
        move(m_by, m_dy, V);
      end
    end
    m_vsprev = v;
    e.fc = 8'(m_fc);
    q.push_back(e);
    @(negedge clk);
    pe = 1'b0;
    hs_in = 1'($urandom_range(0, 1)); vs_in = 1'($urandom_range(0, 1));
    de = 1'($urandom_range(0, 1)); px = 10'($urandom); py = 10'($urandom);
    box_c = 12'($urandom); bg_c = 12'($urandom);
  endtask

  task automatic run_frame(input logic p, input int nprobe);
    int xs[4];
    int ys[4];
    int lo, hi;
    pause = p;
    drive_pixel(1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom_range(0, H - 1), $urandom_range(0, V - 1));
    drive_pixel(1'($urandom_range(0, 1)), 1'b1, 1'b0, $urandom_range(0, H - 1), $urandom_range(0, V - 1));
    if (nprobe > 0) begin
      xs = '{m_bx - 1, m_bx, m_bx + B - 1, m_bx + B};
      ys = '{m_by - 1, m_by, m_by + B - 1, m_by + B};
      for (int i = 0; i < 4; i++) begin
        if (xs[i] >= 0 && xs[i] < H) drive_pixel(1'b1, 1'b1, 1'b1, xs[i], m_by + B - 1);
        if (ys[i] >= 0 && ys[i] < V) drive_pixel(1'b1, 1'b1, 1'b1, m_bx + B - 1, ys[i]);
      end
      lo = (m_bx > 4) ? m_bx - 4 : 0;
      hi = (m_bx + B + 3 < H) ? m_bx + B + 3 : H - 1;
      for (int i = 0; i < nprobe; i++) begin
        drive_pixel(1'($urandom_range(0, 1)), 1'b1, 1'b1, $urandom_range(lo, hi), $urandom_range(0, V - 1));
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rgb"}, {20'd0, red, green, blue}, 32'd0);
    check({tag, "_hsync"}, {31'd0, hs_out}, 32'd1);
    check({tag, "_vsync"}, {31'd0, vs_out}, 32'd1);
    check({tag, "_frames"}, {24'd0, frame_count}, 32'd0);
  endtask

  // monitor: pop on every enabled edge, confirm hold on every disabled edge
  always @(posedge clk) begin
    if (!rst_n) begin
      last = RESET_EXP;
    end else if (pe) begin
      #1;
      if (q.size() == 0) begin
        check("queue_underflow", 32'd1, 32'd0);
      end else begin
        last = q.pop_front();
        check("pixel", {10'd0, current_out()}, {10'd0, last});
      end
    end else begin
      #1;
      check("hold", {10'd0, current_out()}, {10'd0, last});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    model_reset();
    // reset held with clock and strobe active
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pe = ~pe; vs_in = 1'($urandom_range(0, 1)); hs_in = 1'($urandom_range(0, 1)); de = 1'b1;
    end
    check_reset_values("reset");
    @(negedge clk);
    pe = 1'b0; vs_in = 1'b1; hs_in = 1'b1;
    rst_n = 1'b1;

    for (int f = 0; f < 14; f++) run_frame(1'b0, 4);
    for (int f = 0; f < 20; f++) run_frame(1'($urandom_range(0, 1)), 3);

    // asynchronous reset between clock edges
    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    repeat (3) @(negedge clk);
    check_reset_values("async_reset_hold");
    model_reset();
    pe = 1'b0; vs_in = 1'b1;
    rst_n = 1'b1;

    run_frame(1'b0, 4);
    for (int f = 0; f < 299; f++) run_frame(1'b1, (f % 50 == 0) ? 2 : 0);
    @(posedge clk);
    #2;
    check("frame_wrap", {24'd0, frame_count}, 32'd44);
    for (int f = 0; f < 3; f++) run_frame(1'b1, 3);
    for (int f = 0; f < 6; f++) run_frame(1'b0, 3);

    repeat (2) @(posedge clk);
    #2;
    check("queue_empty_end", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
